nibble_serial_alu_ctrl: RTL and testbench

- Sequencer that sits directly upstream and downstream of the 4-bit ALU slice.
- Accepts WIDTH-bit operands and a 3-bit op over a valid/ready handshake.
- Feeds the slice one nibble per cycle, LSB first, chaining carry between nibbles.
- Collects the slice outputs into a WIDTH-bit result with cout/overflow/zero, presented on a valid/ready output.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/nibble_serial_alu_ctrl_if.sv | 30 +++
 rtl/nibble_shifter.sv | 33 +++
 rtl/nibble_serial_alu_ctrl.sv | 140 ++++++++++++++
 tb/tb_nibble_serial_alu_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU controller: op encodings,
// sequencer states and the slice width.
package alu_pkg;

  localparam int NIBBLE = 4;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;
  localparam logic [2:0] OP_ANDN = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_alu_ctrl_if.sv
// Request/response handshake bundle between a client and the nibble-serial
// ALU controller.
interface nibble_serial_alu_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;
  logic             out_overflow;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_cout, out_overflow, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_cout, out_overflow, out_zero
  );

endinterface

// File: rtl/nibble_shifter.sv
// Parallel-load register that shifts right by one nibble, taking a new nibble
// in at the top. q_out exposes the low OUT_W bits of the register.
module nibble_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OUT_W = WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WIDTH-1:0]  din,
  input  logic [NIBBLE-1:0] nib_in,
  output logic [OUT_W-1:0]  q_out
);

  logic [WIDTH-1:0] q_reg;

  // Load wins over shift so a new request can start while the old one drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= din;
    end else if (shift) begin
      q_reg <= {nib_in, q_reg[WIDTH-1:NIBBLE]};
    end
  end

  assign q_out = q_reg[OUT_W-1:0];

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Sequencer around a combinational 4-bit ALU slice: feeds operands one nibble
// per cycle LSB first, chains carry, and assembles a WIDTH-bit result.
module nibble_serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  nibble_serial_alu_ctrl_if.slave   bus,
  output logic [NIBBLE-1:0]         alu_a,
  output logic [NIBBLE-1:0]         alu_b,
  output logic                      alu_cin,
  output logic                      alu_less,
  output logic [2:0]                alu_op,
  input  logic [NIBBLE-1:0]         alu_result,
  input  logic                      alu_cout,
  input  logic                      alu_set,
  input  logic                      alu_overflow
);

  localparam int NIB = WIDTH / NIBBLE;
  localparam int CW  = $clog2(NIB);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic [2:0]       op_reg;
  logic             cout_reg, ovf_reg, zero_reg;

  logic             accept, running, last_nib;
  logic             is_logic, is_add, is_slt, slt_bit;
  logic             res_load;
  logic [WIDTH-1:0] res_q, res_din, final_res;

  assign running  = (state_reg == S_RUN);
  assign last_nib = running && (cnt_reg == CW'(NIB - 1));

  assign bus.in_ready = (state_reg == S_IDLE) || ((state_reg == S_DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign is_logic = (op_reg[1:0] == OP_AND[1:0]) || (op_reg[1:0] == OP_OR[1:0]);
  assign is_add   = (op_reg[1:0] == OP_ADD[1:0]);
  assign is_slt   = (op_reg[1:0] == OP_SLT[1:0]);

  // Sign of the true difference: the MSB-nibble sum bit corrected by overflow.
  assign slt_bit   = alu_set ^ alu_overflow;
  assign final_res = is_slt ? {{(WIDTH-1){1'b0}}, slt_bit}
                            : {alu_result, res_q[WIDTH-1:NIBBLE]};

  // SLT discards the shifted-in nibbles and overwrites the result on the last nibble.
  assign res_load = accept || (last_nib && is_slt);
  assign res_din  = accept ? '0 : final_res;

  nibble_shifter #(.WIDTH(WIDTH), .OUT_W(NIBBLE)) u_a_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .shift  (running),
    .din    (bus.in_a),
    .nib_in ('0),
    .q_out  (alu_a)
  );

  nibble_shifter #(.WIDTH(WIDTH), .OUT_W(NIBBLE)) u_b_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .shift  (running),
    .din    (bus.in_b),
    .nib_in ('0),
    .q_out  (alu_b)
  );

  nibble_shifter #(.WIDTH(WIDTH), .OUT_W(WIDTH)) u_res_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (res_load),
    .shift  (running),
    .din    (res_din),
    .nib_in (alu_result),
    .q_out  (res_q)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_RUN;
      S_RUN:   if (last_nib) state_next = S_DONE;
      S_DONE: begin
        if (accept)             state_next = S_RUN;
        else if (bus.out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      op_reg    <= 3'b000;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        cnt_reg   <= '0;
        carry_reg <= bus.in_op[2];
        op_reg    <= bus.in_op;
      end else if (running) begin
        cnt_reg   <= cnt_reg + CW'(1);
        carry_reg <= alu_cout;
      end
      // Flags are captured once, from the MSB nibble; carry never wraps back.
      if (last_nib) begin
        cout_reg <= is_logic ? 1'b0 : alu_cout;
        ovf_reg  <= is_add & alu_overflow;
        zero_reg <= (final_res == '0);
      end
    end
  end

  assign alu_cin  = carry_reg;
  assign alu_op   = op_reg;
  assign alu_less = 1'b0;

  assign bus.out_valid    = (state_reg == S_DONE);
  assign bus.out_result   = res_q;
  assign bus.out_cout     = cout_reg;
  assign bus.out_overflow = ovf_reg;
  assign bus.out_zero     = zero_reg;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Self-checking bench: behavioural 4-bit slice around the controller, directed
// cases plus randomized ops compared against a whole-word arithmetic model.
module tb_nibble_serial_alu_ctrl;
  import alu_pkg::*;

  localparam int WIDTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] alu_a, alu_b, alu_result;
  logic       alu_cin, alu_less, alu_cout, alu_set, alu_overflow;
  logic [2:0] alu_op;

  int checks = 0;
  int errors = 0;

  nibble_serial_alu_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_cin      (alu_cin),
    .alu_less     (alu_less),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .alu_set      (alu_set),
    .alu_overflow (alu_overflow)
  );

  always #5 clk = ~clk;

  // Combinational 4-bit ALU slice.
  logic [3:0] slice_bb;
  logic [4:0] slice_sum;
  always_comb begin
    slice_bb     = alu_op[2] ? ~alu_b : alu_b;
    slice_sum    = {1'b0, alu_a} + {1'b0, slice_bb} + {4'b0, alu_cin};
    alu_cout     = slice_sum[4];
    alu_set      = slice_sum[3];
    alu_overflow = (alu_a[3] == slice_bb[3]) && (slice_sum[3] != alu_a[3]);
    alu_result   = 4'h0;
    case (alu_op[1:0])
      2'b00: alu_result = alu_a & slice_bb;
      2'b01: alu_result = alu_a | slice_bb;
      2'b10: alu_result = slice_sum[3:0];
      2'b11: alu_result = {3'b000, alu_less};
      default: alu_result = 4'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: plain integer arithmetic on the full operands.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       output logic [15:0] r, output logic c, output logic v, output logic z);
    logic [15:0] bb;
    logic [16:0] s;
    int          sa;
    bb = op[2] ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {16'b0, op[2]};
    sa = int'($signed(a)) + int'($signed(bb)) + int'(op[2]);
    r = 16'h0; c = 1'b0; v = 1'b0;
    case (op[1:0])
      2'b00: r = a & bb;
      2'b01: r = a | bb;
      2'b10: begin r = s[15:0]; c = s[16]; v = (sa > 32767) || (sa < -32768); end
      default: begin r = {15'b0, sa < 0}; c = s[16]; end
    endcase
    z = (r == 16'h0);
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    int n = 0;
    bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_at_request", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("first_nib_op",  {29'b0, alu_op}, {29'b0, op});
    chk("first_nib_cin", {31'b0, alu_cin}, {31'b0, op[2]});
    chk("first_nib_ab",  {24'b0, alu_a, alu_b}, {24'b0, a[3:0], b[3:0]});
  endtask

  task automatic wait_result(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    int lat = 0;
    logic [15:0] r;
    logic c, v, z;
    model(a, b, op, r, c, v, z);
    while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency",  lat, 32'd4);
    chk("result",   {16'b0, bus.out_result}, {16'b0, r});
    chk("cout",     {31'b0, bus.out_cout}, {31'b0, c});
    chk("overflow", {31'b0, bus.out_overflow}, {31'b0, v});
    chk("zero",     {31'b0, bus.out_zero}, {31'b0, z});
    $display("TXN a=%h b=%h op=%b result=%h cout=%b ovf=%b zero=%b lat=%0d",
             a, b, op, bus.out_result, bus.out_cout, bus.out_overflow, bus.out_zero, lat);
  endtask

  task automatic drain(input int stall);
    logic [15:0] held;
    held = bus.out_result;
    repeat (stall) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("stall_hold",  {16'b0, bus.out_result}, {16'b0, held});
      chk("stall_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("valid_drop", {31'b0, bus.out_valid}, 32'd0);
    chk("post_hold",  {16'b0, bus.out_result}, {16'b0, held});
  endtask

  logic [15:0] d_a   [8] = '{16'h7FFF, 16'h1234, 16'h0000, 16'h8000, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0F00};
  logic [15:0] d_b   [8] = '{16'h0001, 16'h1234, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h00F0, 16'h0030};
  logic [2:0]  d_op  [8] = '{OP_ADD, OP_SUB, OP_SUB, OP_SLT, OP_SLT, OP_SLT, OP_ANDN, OP_OR};
  logic [15:0] d_exp [8] = '{16'h8000, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 16'hFF0F, 16'h0F30};

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    logic [2:0]  rop;
    int          ov_seen;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_result", {16'b0, bus.out_result}, 32'd0);
    chk("rst_out_zero", {31'b0, bus.out_zero}, 32'd0);
    chk("rst_alu_op_cin", {28'b0, alu_op, alu_cin}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      start_op(d_a[i], d_b[i], d_op[i]);
      wait_result(d_a[i], d_b[i], d_op[i]);
      chk("directed_const", {16'b0, bus.out_result}, {16'b0, d_exp[i]});
      drain(1);
    end

    // Backpressure for 10 cycles, then a same-cycle back-to-back accept.
    start_op(16'h7FFF, 16'h0001, OP_ADD);
    wait_result(16'h7FFF, 16'h0001, OP_ADD);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_hold", {16'b0, bus.out_result}, 32'h8000);
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    start_op(16'h1234, 16'h0F0F, OP_SUB);
    bus.out_ready = 1'b0;
    chk("b2b_valid_drop", {31'b0, bus.out_valid}, 32'd0);
    wait_result(16'h1234, 16'h0F0F, OP_SUB);
    drain(0);

    // Asynchronous reset in the middle of RUN.
    start_op(16'hABCD, 16'h1357, OP_ADD);
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_alu_ab", {24'b0, alu_a, alu_b}, 32'd0);
    chk("arst_alu_op_cin", {28'b0, alu_op, alu_cin}, 32'd0);
    chk("arst_outs", {13'b0, bus.out_valid, bus.out_result, bus.out_cout, bus.out_overflow, bus.out_zero}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("arst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    ov_seen = 0;
    repeat (8) begin @(posedge clk); #1; if (bus.out_valid) ov_seen++; end
    chk("arst_no_valid", ov_seen, 32'd0);

    for (int i = 0; i < 50; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 3'($urandom_range(0, 7));
      if (i % 5 == 0) rb = ra;
      start_op(ra, rb, rop);
      wait_result(ra, rb, rop);
      drain($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
